imem_access_arbiter: RTL and testbench
======================================

// Module: imem_access_arbiter
// PURPOSE
//  Shares the single-port, synchronous-read instruction memory between the core fetch path and a
//  boot loader write port. After reset only the loader is served (BOOT); a boot_done pulse moves
//  to RUN, where fetch has priority and a burst counter keeps the loader from being starved.
//  Address checks and the one-cycle read return path live here. The memory itself stays a plain array.
// PARAMETERS
//  ADDR_WIDTH     32  width of byte addresses on fetch/load ports
//  WORDS          32  memory depth in 32-bit words; IDX_W = $clog2(WORDS)
//  MAX_FETCH_RUN   4  consecutive fetch grants allowed while load_req is pending before one load grant
// PORTS
//  clk           in   1           clock, all state on rising edge
//  reset         in   1           synchronous, active-high
//  boot_done     in   1           one-cycle pulse; BOOT -> RUN
//  fetch_req     in   1           fetch read request
//  fetch_addr    in   ADDR_WIDTH  byte address of instruction
//  fetch_gnt     out  1           request accepted this cycle (combinational)
//  fetch_valid   out  1           fetch_data valid (cycle after grant)
//  fetch_data    out  32          instruction word
//  fetch_err     out  1           with fetch_valid: address misaligned or out of range
//  load_req      in   1           loader write request
//  load_addr     in   ADDR_WIDTH  byte address
//  load_wdata    in   32          word to write
//  load_gnt      out  1           write accepted this cycle (combinational)
//  load_err      out  1           registered pulse, cycle after a granted bad-address load
//  in_run        out  1           1 when FSM is in RUN
//  mem_en        out  1           memory access strobe
//  mem_we        out  1           1 = write
//  mem_idx       out  IDX_W       word index = addr[IDX_W+1:2]
//  mem_wdata     out  32          write data
//  mem_rdata     in   32          read data, valid cycle after mem_en && !mem_we
// BEHAVIOUR
//  Reset: state=BOOT, run_cnt=0, all grants/strobes/valid/err=0, fetch_data=0. No in-flight read survives.
//  FSM: BOOT -> RUN on boot_done; RUN holds until reset. boot_done in RUN is ignored.
//  BOOT: load_gnt=load_req; fetch_gnt=0 always (fetch_req ignored, no error).
//  RUN arbitration, one grant per cycle:
//   - only one requester: it is granted.
//   - both: fetch granted unless run_cnt==MAX_FETCH_RUN, then load granted.
//   - run_cnt increments on a fetch grant while load_req=1; clears on a load grant or when load_req=0.
//  Address legality: bad = addr[1:0]!=0 or (addr>>2) >= WORDS.
//   - granted bad fetch: mem_en=0; next cycle fetch_valid=1, fetch_err=1, fetch_data=0 (NOP).
//   - granted bad load: mem_en=0, no write; next cycle load_err=1. Still consumes the grant.
//  Good grant: mem_en=1, mem_we=1 for load, mem_idx/mem_wdata from the granted port, same cycle.
//  Read return: fetch_valid=1, fetch_err=0, fetch_data=mem_rdata the cycle after a good fetch grant.
//   fetch_data holds its last value when fetch_valid=0.
//  Back-to-back fetch grants give fetch_valid on consecutive cycles (throughput 1/cycle).
//  Load and fetch same index in consecutive cycles: the read sees the new word (write then read).
//  Reset mid-read: fetch_valid=0 on the cycle after reset; the pending return is dropped.
//  mem_idx/mem_wdata = 0 when mem_en=0.
// TESTING
//  1 BOOT: fetch_req=1 @0x0, load 0x20080014 @0x0 -> load_gnt=1, fetch_gnt=0, mem word0=0x20080014
//  2 boot_done, fetch @0x0,0x4,0x8 back-to-back -> fetch_valid 3 consecutive cycles:
//    0x20080014, 0x2009000F, 0x0128802A
//  3 RUN, fetch_req and load_req held high 12 cycles -> grant pattern FFFFL FFFFL FF
//  4 fetch @0x2 and @0x80 (WORDS=32) -> fetch_err=1, fetch_data=0, mem_en never asserted
//  5 load @0x7C wdata 0xDEADBEEF, then fetch @0x7C next cycle -> fetch_data=0xDEADBEEF
//  6 reset asserted the cycle after a fetch grant -> fetch_valid=0, in_run=0, fetch_gnt=0 until boot_done

Source files
------------

// File: rtl/imem_access_if.sv
// Request/response bundle between the fetch/loader clients and the
// instruction-memory arbiter. Clients use the master modport and the
// arbiter uses the slave modport.
interface imem_access_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_gnt;
  logic                  fetch_valid;
  logic [31:0]           fetch_data;
  logic                  fetch_err;

  logic                  load_req;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [31:0]           load_wdata;
  logic                  load_gnt;
  logic                  load_err;

  modport master (
    output fetch_req, fetch_addr, load_req, load_addr, load_wdata,
    input  fetch_gnt, fetch_valid, fetch_data, fetch_err, load_gnt, load_err
  );

  modport slave (
    input  fetch_req, fetch_addr, load_req, load_addr, load_wdata,
    output fetch_gnt, fetch_valid, fetch_data, fetch_err, load_gnt, load_err
  );
endinterface

// File: rtl/imem_access_arbiter.sv
// Arbitrates the single-port synchronous-read instruction memory between the
// core fetch path and the boot loader. BOOT serves only the loader; RUN gives
// fetch priority, bounded by a burst counter so a pending load cannot starve.
// Bad addresses never reach the memory: fetches return an error NOP, loads
// raise a one-cycle error pulse.
module imem_access_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int WORDS         = 32,
  parameter int MAX_FETCH_RUN = 4,
  // Derived from WORDS; not meant to be overridden.
  parameter int IDX_W         = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot_done,
  imem_access_if.slave      bus,
  output logic              in_run,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_idx,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(MAX_FETCH_RUN + 1);
  localparam logic [ADDR_WIDTH-1:0] WORDS_LIM = ADDR_WIDTH'(WORDS);
  localparam logic [CNT_W-1:0]      RUN_LIM   = CNT_W'(MAX_FETCH_RUN);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] run_cnt;
  logic             fetch_gnt, load_gnt;
  logic             fetch_bad, load_bad;
  logic             rd_pend, rd_err;
  logic             load_err_q;
  logic [31:0]      data_hold;
  logic [31:0]      fetch_data;

  // Misaligned or beyond the last word.
  assign fetch_bad = (bus.fetch_addr[1:0] != 2'b00) || ((bus.fetch_addr >> 2) >= WORDS_LIM);
  assign load_bad  = (bus.load_addr[1:0]  != 2'b00) || ((bus.load_addr  >> 2) >= WORDS_LIM);

  // State register: BOOT after reset, RUN once boot_done is seen.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (reset) state <= BOOT;
    else       state <= state_next;
  end

  // Next-state logic: RUN is sticky until reset; boot_done in RUN is ignored.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves the
    // signal unassigned, which would otherwise infer a latch.
    state_next = state;
    if (state == BOOT && boot_done) state_next = RUN;
  end

  // Output logic: one grant per cycle plus the memory strobe for good addresses.
  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    unique case (state)
      BOOT: load_gnt = bus.load_req;
      RUN: begin
        if (bus.fetch_req && bus.load_req) begin
          if (run_cnt == RUN_LIM) load_gnt  = 1'b1;
          else                    fetch_gnt = 1'b1;
        end else begin
          fetch_gnt = bus.fetch_req;
          load_gnt  = bus.load_req;
        end
      end
      default: ;
    endcase

    mem_en    = (fetch_gnt && !fetch_bad) || (load_gnt && !load_bad);
    mem_we    = load_gnt && !load_bad;
    mem_idx   = '0;
    mem_wdata = '0;
    if (load_gnt && !load_bad) begin
      mem_idx   = bus.load_addr[IDX_W+1:2];
      mem_wdata = bus.load_wdata;
    end else if (fetch_gnt && !fetch_bad) begin
      mem_idx   = bus.fetch_addr[IDX_W+1:2];
    end
  end

  // Burst counter: counts fetch wins while the loader waits, cleared when the
  // loader is served or stops asking.
  always_ff @(posedge clk) begin
    if (reset || state != RUN)       run_cnt <= '0;
    else if (load_gnt || !bus.load_req) run_cnt <= '0;
    else if (fetch_gnt)              run_cnt <= run_cnt + 1'b1;
  end

  // Return path: remembers last cycle's fetch grant, its error status, and a
  // bad-load grant for the registered error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend    <= 1'b0;
      rd_err     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      rd_pend    <= fetch_gnt;
      rd_err     <= fetch_gnt && fetch_bad;
      load_err_q <= load_gnt && load_bad;
    end
  end

  // Holding register so fetch_data keeps the last returned word between returns.
  always_ff @(posedge clk) begin
    if (reset)        data_hold <= '0;
    else if (rd_pend) data_hold <= fetch_data;
  end

  // Memory data is only valid the cycle after the read, so it is steered
  // straight through; errored fetches return a zero NOP.
  assign fetch_data = rd_pend ? (rd_err ? 32'h0 : mem_rdata) : data_hold;

  assign bus.fetch_gnt   = fetch_gnt;
  assign bus.load_gnt    = load_gnt;
  assign bus.fetch_valid = rd_pend;
  assign bus.fetch_err   = rd_pend && rd_err;
  assign bus.fetch_data  = fetch_data;
  assign bus.load_err    = load_err_q;
  assign in_run          = (state == RUN);

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter with a plain synchronous-read memory
// array attached to the mem_* port.
module tb_imem_access_arbiter;

  localparam int AW = 32;

  logic        clk;
  logic        reset;
  logic        boot_done;
  logic        in_run;
  logic        mem_en;
  logic        mem_we;
  logic [4:0]  mem_idx;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem_array [32];

  int total;
  int bad;

  imem_access_if #(.ADDR_WIDTH(AW)) bus ();

  imem_access_arbiter #(
    .ADDR_WIDTH(AW),
    .WORDS(32),
    .MAX_FETCH_RUN(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .boot_done(boot_done),
    .bus(bus),
    .in_run(in_run),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_idx(mem_idx),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: write or synchronous read on mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_array[mem_idx] <= mem_wdata;
      else        mem_rdata <= mem_array[mem_idx];
    end
  end

  task automatic drive_idle();
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.load_req   = 1'b0;
    bus.load_addr  = '0;
    bus.load_wdata = '0;
    boot_done      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_run !== 1'b0) begin bad++; $display("FAIL reset_in_run got=%0b want=0", in_run); end
    total++; if (bus.fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_fetch_valid got=%0b want=0", bus.fetch_valid); end
    total++; if (bus.fetch_data !== 32'h0) begin bad++; $display("FAIL reset_fetch_data got=%h want=0", bus.fetch_data); end
    total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL reset_load_err got=%0b want=0", bus.load_err); end
    total++; if ({bus.fetch_gnt, bus.load_gnt, mem_en} !== 3'b000) begin bad++;
      $display("FAIL reset_strobes got=%b want=000", {bus.fetch_gnt, bus.load_gnt, mem_en}); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // BOOT: the loader fills words 0..2 while fetch_req is ignored.
  task automatic test_boot_load();
    logic [31:0] words [3];
    words[0] = 32'h20080014;
    words[1] = 32'h2009000F;
    words[2] = 32'h0128802A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = '0;
      bus.load_req   = 1'b1;
      bus.load_addr  = 32'(4 * i);
      bus.load_wdata = words[i];
      #1;
      total++; if ({bus.load_gnt, bus.fetch_gnt} !== 2'b10) begin bad++;
        $display("FAIL boot_gnt[%0d] got load=%0b fetch=%0b want load=1 fetch=0", i, bus.load_gnt, bus.fetch_gnt); end
      total++; if ({mem_en, mem_we, mem_idx, mem_wdata} !== {2'b11, 5'(i), words[i]}) begin bad++;
        $display("FAIL boot_mem[%0d] got en=%0b we=%0b idx=%0d wd=%h want en=1 we=1 idx=%0d wd=%h",
                 i, mem_en, mem_we, mem_idx, mem_wdata, i, words[i]); end
      @(posedge clk);
      #1;
      total++; if (mem_array[i] !== words[i]) begin bad++;
        $display("FAIL boot_word[%0d] got=%h want=%h", i, mem_array[i], words[i]); end
      total++; if ({bus.fetch_valid, bus.fetch_err} !== 2'b00) begin bad++;
        $display("FAIL boot_no_fetch[%0d] got valid=%0b err=%0b want 0 0", i, bus.fetch_valid, bus.fetch_err); end
    end
    @(negedge clk);
    drive_idle();
  endtask

  // boot_done, then three back-to-back fetches returning on consecutive cycles.
  task automatic test_back_to_back();
    logic [31:0] exp [3];
    exp[0] = 32'h20080014;
    exp[1] = 32'h2009000F;
    exp[2] = 32'h0128802A;
    boot_done = 1'b1;
    @(posedge clk);
    #1;
    total++; if (in_run !== 1'b1) begin bad++; $display("FAIL run_entry got=%0b want=1", in_run); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      boot_done      = 1'b0;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'(4 * i);
      #1;
      total++; if (bus.fetch_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt[%0d] got=%0b want=1", i, bus.fetch_gnt); end
      @(posedge clk);
      #1;
      total++; if ({bus.fetch_valid, bus.fetch_err, bus.fetch_data} !== {2'b10, exp[i]}) begin bad++;
        $display("FAIL b2b_data[%0d] got valid=%0b err=%0b data=%h want valid=1 err=0 data=%h",
                 i, bus.fetch_valid, bus.fetch_err, bus.fetch_data, exp[i]); end
    end
    @(negedge clk);
    bus.fetch_req = 1'b0;
    @(posedge clk);
    #1;
    total++; if ({bus.fetch_valid, bus.fetch_data} !== {1'b0, exp[2]}) begin bad++;
      $display("FAIL b2b_hold got valid=%0b data=%h want valid=0 data=%h", bus.fetch_valid, bus.fetch_data, exp[2]); end
  endtask

  // Both requesters held for 12 cycles: FFFFL FFFFL FF.
  task automatic test_fairness();
    logic f_exp, l_exp;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0;
      bus.load_req   = 1'b1;
      bus.load_addr  = 32'h10;
      bus.load_wdata = 32'h11111111;
      l_exp = (i == 4) || (i == 9);
      f_exp = !l_exp;
      #1;
      total++; if ({bus.fetch_gnt, bus.load_gnt} !== {f_exp, l_exp}) begin bad++;
        $display("FAIL fair_pattern[%0d] got f=%0b l=%0b want f=%0b l=%0b",
                 i, bus.fetch_gnt, bus.load_gnt, f_exp, l_exp); end
      @(posedge clk);
    end
    @(negedge clk);
    drive_idle();
    @(posedge clk);
  endtask

  // Misaligned / out-of-range fetches and an out-of-range load.
  task automatic test_bad_addr();
    logic [31:0] addrs [2];
    addrs[0] = 32'h2;
    addrs[1] = 32'h80;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = addrs[i];
      #1;
      total++; if ({bus.fetch_gnt, mem_en} !== 2'b10) begin bad++;
        $display("FAIL badf_gnt[%0d] got gnt=%0b mem_en=%0b want gnt=1 mem_en=0", i, bus.fetch_gnt, mem_en); end
      @(posedge clk);
      #1;
      total++; if ({bus.fetch_valid, bus.fetch_err, bus.fetch_data} !== {2'b11, 32'h0}) begin bad++;
        $display("FAIL badf_resp[%0d] got valid=%0b err=%0b data=%h want valid=1 err=1 data=0",
                 i, bus.fetch_valid, bus.fetch_err, bus.fetch_data); end
    end
    @(negedge clk);
    bus.fetch_req  = 1'b0;
    bus.load_req   = 1'b1;
    bus.load_addr  = 32'h80;
    bus.load_wdata = 32'hCAFEF00D;
    #1;
    total++; if ({bus.load_gnt, mem_en} !== 2'b10) begin bad++;
      $display("FAIL badl_gnt got gnt=%0b mem_en=%0b want gnt=1 mem_en=0", bus.load_gnt, mem_en); end
    @(posedge clk);
    #1;
    total++; if ({bus.load_err, bus.fetch_valid} !== 2'b10) begin bad++;
      $display("FAIL badl_err got load_err=%0b fetch_valid=%0b want 1 0", bus.load_err, bus.fetch_valid); end
    @(negedge clk);
    bus.load_req = 1'b0;
    @(posedge clk);
    #1;
    total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL badl_pulse got=%0b want=0", bus.load_err); end
  endtask

  // Write the last word, read it back the very next cycle.
  task automatic test_write_then_read();
    @(negedge clk);
    bus.load_req   = 1'b1;
    bus.load_addr  = 32'h7C;
    bus.load_wdata = 32'hDEADBEEF;
    #1;
    total++; if ({bus.load_gnt, mem_en, mem_we, mem_idx} !== {3'b111, 5'd31}) begin bad++;
      $display("FAIL wr_last got gnt=%0b en=%0b we=%0b idx=%0d want 1 1 1 31", bus.load_gnt, mem_en, mem_we, mem_idx); end
    @(negedge clk);
    bus.load_req   = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h7C;
    #1;
    total++; if ({bus.fetch_gnt, mem_en, mem_we, mem_idx, mem_wdata} !== {3'b110, 5'd31, 32'h0}) begin bad++;
      $display("FAIL rd_last got gnt=%0b en=%0b we=%0b idx=%0d wd=%h want 1 1 0 31 0",
               bus.fetch_gnt, mem_en, mem_we, mem_idx, mem_wdata); end
    @(posedge clk);
    #1;
    total++; if ({bus.fetch_valid, bus.fetch_err, bus.fetch_data} !== {2'b10, 32'hDEADBEEF}) begin bad++;
      $display("FAIL wr_rd_data got valid=%0b err=%0b data=%h want 1 0 deadbeef",
               bus.fetch_valid, bus.fetch_err, bus.fetch_data); end
    @(negedge clk);
    bus.fetch_req = 1'b0;
    @(posedge clk);
  endtask

  // Reset lands in the cycle after a fetch grant; the return is dropped.
  task automatic test_reset_mid_read();
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h4;
    #1;
    total++; if (bus.fetch_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt got=%0b want=1", bus.fetch_gnt); end
    @(negedge clk);
    bus.fetch_req = 1'b0;
    reset         = 1'b1;
    @(posedge clk);
    #1;
    total++; if ({bus.fetch_valid, in_run} !== 2'b00) begin bad++;
      $display("FAIL mid_drop got valid=%0b in_run=%0b want 0 0", bus.fetch_valid, in_run); end
    @(negedge clk);
    reset         = 1'b0;
    bus.fetch_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({bus.fetch_gnt, in_run} !== 2'b00) begin bad++;
        $display("FAIL post_reset_gnt[%0d] got gnt=%0b in_run=%0b want 0 0", i, bus.fetch_gnt, in_run); end
      @(posedge clk);
      #1;
      total++; if (bus.fetch_valid !== 1'b0) begin bad++;
        $display("FAIL post_reset_valid[%0d] got=%0b want=0", i, bus.fetch_valid); end
      @(negedge clk);
    end
    boot_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    boot_done = 1'b0;
    #1;
    total++; if ({in_run, bus.fetch_gnt} !== 2'b11) begin bad++;
      $display("FAIL rerun got in_run=%0b gnt=%0b want 1 1", in_run, bus.fetch_gnt); end
    @(posedge clk);
    #1;
    total++; if ({bus.fetch_valid, bus.fetch_data} !== {1'b1, 32'h2009000F}) begin bad++;
      $display("FAIL rerun_data got valid=%0b data=%h want 1 2009000f", bus.fetch_valid, bus.fetch_data); end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_boot_load();
    test_back_to_back();
    test_fairness();
    test_bad_addr();
    test_write_then_read();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
